serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
//  Digit-serial, parametrised successor to the single-bit full adder.
//  Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using one DIGIT-wide adder slice.
//  Valid/ready handshakes on input and output; sits between operand producer and result consumer
//  in area-constrained datapaths. One operation in flight at a time.
//
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=1)
//  DIGIT  1  bits added per clock; must divide WIDTH, else elaboration $error
//  K = WIDTH/DIGIT (derived): number of RUN cycles per operation
//
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A (unsigned / two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b+cin, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. On edge with rst=1:
//    state=IDLE, count=0, out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 from next cycle.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready: capture a,b into shift regs, cin into carry reg,
//    count=0, go to RUN.
//  - RUN: in_ready=0. Each edge adds low DIGIT bits of both regs plus carry, shifts regs right by DIGIT,
//    shifts result digit into accumulator MSB end, updates carry, increments count.
//    On the K-th RUN edge: load sum<=accumulator, cout<=final carry, out_valid<=1, go to DONE.
//  - Latency: out_valid rises exactly K cycles after the accepting edge (WIDTH=8,DIGIT=1: 8).
//  - DONE: out_valid=1; sum/cout held stable until out_valid&out_ready, then out_valid<=0, go to IDLE.
//    in_ready=0 in DONE; new operands are accepted no earlier than the cycle after handoff.
//  - sum/cout change only on DONE entry; they keep the last result in IDLE/RUN.
//  - in_valid while in_ready=0 is ignored (no queuing). a/b may change freely after acceptance.
//  - Arithmetic modulo 2^WIDTH; cout is the true carry.
//    a=b=all-ones, cin=1 -> sum=all-ones, cout=1.
//  - Reset mid-RUN or mid-DONE aborts the operation; no out_valid pulse for it.
//  - Back-to-back with out_ready held high: out_valid high for exactly 1 cycle per result.
//
// CONFIGURATION
//  - SERIAL_ADDER_OVF_EN defined: port ovf present, updated with sum on DONE entry.
//    ovf = carry into bit WIDTH-1 XOR cout (signed overflow); held like sum; reset 0.
//  - Not defined: ovf port and logic absent; all other behaviour identical.
//
// TESTING (WIDTH=8 unless noted)
//  1. DIGIT=1, a=8'h35, b=8'h4A, cin=0 -> 8 cycles later out_valid=1, sum=8'h7F, cout=0.
//  2. DIGIT=1, a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; with OVF_EN ovf=0.
//  3. DIGIT=4, a=8'h7F, b=8'h01, cin=0 -> out_valid after 2 cycles, sum=8'h80, cout=0, ovf=1 (OVF_EN).
//  4. out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0, pulsed in_valid ignored.
//     Then out_ready=1 -> IDLE next cycle.
//  5. rst=1 at 3rd RUN cycle -> next cycle IDLE, in_ready=1, out_valid never asserts, sum=0.
//  6. Exhaustive WIDTH=2,DIGIT=1: all 32 (a,b,cin) combos, out_ready=1 -> {cout,sum}==a+b+cin each time.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   in_valid/in_ready  operand handshake (producer -> adder)
//   a, b, cin          operands and carry-in
//   out_valid/out_ready result handshake (adder -> consumer)
//   sum, cout          result and carry-out
//   ovf                signed overflow, present only with SERIAL_ADDER_OVF_EN
// Modports: slave = adder side, master = producer/consumer side.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder computing a + b + cin, DIGIT bits per clock over
// K = WIDTH/DIGIT cycles using a single DIGIT-wide adder slice. One operation in flight.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serial_adder_if.slave: in_valid/in_ready, a, b, cin, out_valid/out_ready, sum, cout
//        (+ ovf when SERIAL_ADDER_OVF_EN is defined)
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned K    = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW = $clog2(K + 1);

  if (WIDTH < 1 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: DIGIT must be nonzero and divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  // Single DIGIT-wide slice; top bit is the digit carry-out.
  logic [DIGIT:0]          dig_sum;
  logic [WIDTH+DIGIT-1:0]  acc_cat;
  logic [WIDTH-1:0]        acc_nxt;

  assign dig_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
  // New digit enters at the MSB end; after K shifts digit 0 sits at bit 0.
  assign acc_cat = {dig_sum[DIGIT-1:0], acc_q};
  assign acc_nxt = acc_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_nxt;
        carry_d = dig_sum[DIGIT];
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(K - 1)) begin
          sum_d   = acc_nxt;
          cout_d  = dig_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
          // Same-sign operands producing an opposite-sign MSB: equivalent to
          // carry-into-MSB XOR carry-out.
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dig_sum[DIGIT-1] != a_q[DIGIT-1]);
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder. Three instances share clk/rst:
//   sel 0: WIDTH=8 DIGIT=1, sel 1: WIDTH=8 DIGIT=4, sel 2: WIDTH=2 DIGIT=1.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared driver state; only the selected instance sees in_valid.
  int         sel;
  logic       drv_valid;
  logic       drv_ready;
  logic [7:0] drv_a;
  logic [7:0] drv_b;
  logic       drv_cin;

  serial_adder_if #(.WIDTH(8)) bus_d1 ();
  serial_adder_if #(.WIDTH(8)) bus_d4 ();
  serial_adder_if #(.WIDTH(2)) bus_w2 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (.clk(clk), .rst(rst), .bus(bus_d1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (.clk(clk), .rst(rst), .bus(bus_d4));
  serial_adder #(.WIDTH(2), .DIGIT(1)) dut_w2 (.clk(clk), .rst(rst), .bus(bus_w2));

  assign bus_d1.in_valid  = drv_valid && (sel == 0);
  assign bus_d4.in_valid  = drv_valid && (sel == 1);
  assign bus_w2.in_valid  = drv_valid && (sel == 2);
  assign bus_d1.a         = drv_a;
  assign bus_d1.b         = drv_b;
  assign bus_d4.a         = drv_a;
  assign bus_d4.b         = drv_b;
  assign bus_w2.a         = drv_a[1:0];
  assign bus_w2.b         = drv_b[1:0];
  assign bus_d1.cin       = drv_cin;
  assign bus_d4.cin       = drv_cin;
  assign bus_w2.cin       = drv_cin;
  assign bus_d1.out_ready = drv_ready;
  assign bus_d4.out_ready = drv_ready;
  assign bus_w2.out_ready = drv_ready;

  logic       obs_valid;
  logic       obs_ready;
  logic [7:0] obs_sum;
  logic       obs_cout;
  logic       obs_ovf;

  always_comb begin
    obs_valid = bus_d1.out_valid;
    obs_ready = bus_d1.in_ready;
    obs_sum   = bus_d1.sum;
    obs_cout  = bus_d1.cout;
    obs_ovf   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    obs_ovf   = bus_d1.ovf;
`endif
    if (sel == 1) begin
      obs_valid = bus_d4.out_valid;
      obs_ready = bus_d4.in_ready;
      obs_sum   = bus_d4.sum;
      obs_cout  = bus_d4.cout;
`ifdef SERIAL_ADDER_OVF_EN
      obs_ovf   = bus_d4.ovf;
`endif
    end else if (sel == 2) begin
      obs_valid = bus_w2.out_valid;
      obs_ready = bus_w2.in_ready;
      obs_sum   = {6'd0, bus_w2.sum};
      obs_cout  = bus_w2.cout;
`ifdef SERIAL_ADDER_OVF_EN
      obs_ovf   = bus_w2.ovf;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on instance s, check exact latency and result. If drv_ready is
  // high, also checks the single-cycle out_valid pulse; otherwise leaves the DUT in DONE.
  task automatic run_op(input int s, input logic [7:0] a_in, input logic [7:0] b_in,
                        input logic c, input string name);
    int          w = (s == 2) ? 2 : 8;
    int          k = (s == 0) ? 8 : 2;
    logic [7:0]  mask = (w == 8) ? 8'hFF : 8'h03;
    logic [7:0]  a = a_in & mask;
    logic [7:0]  b = b_in & mask;
    int          full = int'(a) + int'(b) + int'(c);
    logic [7:0]  exp_sum = 8'(full) & mask;
    logic        exp_cout = full[w];
    logic        exp_ovf = (a[w-1] == b[w-1]) && (exp_sum[w-1] != a[w-1]);
    bit          seen = 0;
    sel = s;
    #0;
    for (int i = 0; i < 20; i++) begin
      if (obs_ready) begin seen = 1; break; end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s wait_in_ready: in_ready stayed 0, required 1", name);
      return;
    end
    drv_a = a; drv_b = b; drv_cin = c; drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    drv_a = 8'($urandom); drv_b = 8'($urandom); drv_cin = 1'($urandom);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_busy: got %b, required 0", name, obs_ready);
    end
    for (int i = 1; i <= k; i++) begin
      tick();
      checks++;
      if (obs_valid !== (i == k)) begin
        errors++;
        $display("FAIL %s latency cycle %0d: out_valid %b, required %b", name, i, obs_valid,
                 (i == k));
      end
    end
    checks++;
    if (obs_sum !== exp_sum || obs_cout !== exp_cout) begin
      errors++;
      $display("FAIL %s result: sum %h cout %b, required sum %h cout %b", name, obs_sum,
               obs_cout, exp_sum, exp_cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (obs_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b, required %b", name, obs_ovf, exp_ovf);
    end
`endif
    if (drv_ready) begin
      tick();
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_sum !== exp_sum) begin
        errors++;
        $display("FAIL %s handoff: out_valid %b in_ready %b sum %h, required 0 1 %h", name,
                 obs_valid, obs_ready, obs_sum, exp_sum);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_sum !== 8'h00 || obs_cout !== 1'b0
          || obs_ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset inst %0d: rdy %b vld %b sum %h cout %b ovf %b, required 1 0 00 0 0",
                 s, obs_ready, obs_valid, obs_sum, obs_cout, obs_ovf);
      end
    end
  endtask

  task automatic test_directed();
    drv_ready = 1'b1;
    run_op(0, 8'h35, 8'h4A, 1'b0, "d1_35_4a");
    run_op(0, 8'hFF, 8'hFF, 1'b1, "d1_ff_ff_c1");
    run_op(1, 8'h7F, 8'h01, 1'b0, "d4_7f_01");
    run_op(1, 8'hFF, 8'hFF, 1'b1, "d4_ff_ff_c1");
  endtask

  task automatic test_hold();
    drv_ready = 1'b0;
    run_op(0, 8'h35, 8'h4A, 1'b0, "hold_op");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        drv_a = 8'h01; drv_b = 8'h02; drv_cin = 1'b0; drv_valid = 1'b1;
      end
      tick();
      drv_valid = 1'b0;
      checks++;
      if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_sum !== 8'h7F || obs_cout !== 1'b0)
      begin
        errors++;
        $display("FAIL hold cycle %0d: vld %b rdy %b sum %h cout %b, required 1 0 7f 0", i,
                 obs_valid, obs_ready, obs_sum, obs_cout);
      end
    end
    drv_ready = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold release: vld %b rdy %b, required 0 1", obs_valid, obs_ready);
    end
    tick();
    checks++;
    if (obs_ready !== 1'b1 || obs_sum !== 8'h7F) begin
      errors++;
      $display("FAIL hold no_queue: rdy %b sum %h, required 1 7f", obs_ready, obs_sum);
    end
  endtask

  task automatic test_reset_mid_run();
    sel = 0;
    drv_ready = 1'b1;
    drv_a = 8'hAA; drv_b = 8'h11; drv_cin = 1'b1; drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_sum !== 8'h00 || obs_cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: rdy %b vld %b sum %h cout %b, required 1 0 00 0",
               obs_ready, obs_valid, obs_sum, obs_cout);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_run_no_valid cycle %0d: out_valid %b, required 0", i, obs_valid);
      end
    end
  endtask

  task automatic test_exhaustive_w2();
    drv_ready = 1'b1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run_op(2, 8'(a), 8'(b), 1'(c), $sformatf("w2_%0d_%0d_%0d", a, b, c));
  endtask

  task automatic test_random();
    drv_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom),
             $sformatf("rand_%0d", i));
  endtask

  task automatic test_back_to_back();
    drv_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("b2b_d4_%0d", i));
    for (int i = 0; i < 4; i++)
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("b2b_d1_%0d", i));
  endtask

  initial begin
    sel = 0; drv_valid = 1'b0; drv_ready = 1'b0;
    drv_a = 8'h00; drv_b = 8'h00; drv_cin = 1'b0; rst = 1'b1;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_exhaustive_w2();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
